// File: rtl/hvsp_op_sequencer.sv
// HVSP operation sequencer: expands one host command into a chain of SDI/SII
// frames for the 11-bit shifter, captures read-back bytes and polls SDO-ready
// after chip erase.
module hvsp_op_sequencer #(
  parameter int unsigned POLL_TIMEOUT = 240000,
  parameter int unsigned POLL_SETTLE  = 4
) (
  input  logic        osc,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  output logic        cmd_ready,
  output logic        busy,
  output logic [15:0] result,
  output logic        err_timeout,
  output logic        err_badop,
  output logic [7:0]  frame_sdi,
  output logic [7:0]  frame_sii,
  output logic        frame_start,
  input  logic        frame_done,
  input  logic [10:0] frame_sdo,
  input  logic        sdo_pin
);

  localparam logic [2:0] OpNop       = 3'd0;
  localparam logic [2:0] OpReadFlash = 3'd1;
  localparam logic [2:0] OpReadEep   = 3'd2;
  localparam logic [2:0] OpReadSig   = 3'd3;
  localparam logic [2:0] OpChipErase = 3'd4;

  // Poll counter counts cycles since entering POLL; the WAIT cycle that saw
  // frame_done is the first settle cycle, hence the -1.
  localparam logic [17:0] SettleLast  = 18'(POLL_SETTLE - 1);
  localparam logic [17:0] TimeoutLast = 18'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StPoll, StDone} state_t;

  typedef struct packed {
    logic [7:0] sdi;
    logic [7:0] sii;
    logic       cap_lo;
    logic       cap_hi;
    logic       last;
  } frame_t;

  // Frame table: (SDI, SII, capture-low, capture-high, last) per op and index.
  function automatic frame_t frame_lookup(input logic [2:0] op, input logic [2:0] idx,
                                          input logic [15:0] addr);
    frame_t f;
    f = '0;
    case (op)
      OpReadFlash: begin
        case (idx)
          3'd0: f = {8'h02, 8'h4C, 3'b000};
          3'd1: f = {addr[7:0], 8'h0C, 3'b000};
          3'd2: f = {addr[15:8], 8'h1C, 3'b000};
          3'd3: f = {8'h00, 8'h68, 3'b000};
          3'd4: f = {8'h00, 8'h6C, 3'b100};
          3'd5: f = {8'h00, 8'h78, 3'b000};
          3'd6: f = {8'h00, 8'h7C, 3'b011};
          default: f = '0;
        endcase
      end
      OpReadEep: begin
        case (idx)
          3'd0: f = {8'h03, 8'h4C, 3'b000};
          3'd1: f = {addr[7:0], 8'h0C, 3'b000};
          3'd2: f = {addr[15:8], 8'h1C, 3'b000};
          3'd3: f = {8'h00, 8'h68, 3'b000};
          3'd4: f = {8'h00, 8'h6C, 3'b101};
          default: f = '0;
        endcase
      end
      OpReadSig: begin
        case (idx)
          3'd0: f = {8'h08, 8'h4C, 3'b000};
          3'd1: f = {addr[7:0], 8'h0C, 3'b000};
          3'd2: f = {8'h00, 8'h68, 3'b000};
          3'd3: f = {8'h00, 8'h6C, 3'b101};
          default: f = '0;
        endcase
      end
      OpChipErase: begin
        case (idx)
          3'd0: f = {8'h80, 8'h4C, 3'b000};
          3'd1: f = {8'h00, 8'h64, 3'b000};
          3'd2: f = {8'h00, 8'h6C, 3'b001};
          default: f = '0;
        endcase
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [2:0]  idx_q, idx_d;
  logic [17:0] cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_badop_q, err_badop_d;
  logic        busy_q, busy_d;
  logic [7:0]  sdi_q, sdi_d;
  logic [7:0]  sii_q, sii_d;
  logic        sdo_meta_q, sdo_sync_q;
  frame_t      cur_frame, nxt_frame;

  // Only the data byte of the SDO capture is used.
  logic unused_sdo;
  assign unused_sdo = ^{frame_sdo[10], frame_sdo[1:0]};

  assign cmd_ready   = (state_q == StIdle) && !busy_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign err_timeout = err_timeout_q;
  assign err_badop   = err_badop_q;
  assign frame_sdi   = sdi_q;
  assign frame_sii   = sii_q;

  // Two-flop synchroniser for the raw SDO pin.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sdo_meta_q <= 1'b0;
      sdo_sync_q <= 1'b0;
    end else begin
      sdo_meta_q <= sdo_pin;
      sdo_sync_q <= sdo_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= OpNop;
      addr_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      err_timeout_q <= 1'b0;
      err_badop_q   <= 1'b0;
      busy_q        <= 1'b0;
      sdi_q         <= '0;
      sii_q         <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      err_timeout_q <= err_timeout_d;
      err_badop_q   <= err_badop_d;
      busy_q        <= busy_d;
      sdi_q         <= sdi_d;
      sii_q         <= sii_d;
    end
  end

  // Next-state logic, frame issue, capture and SDO-ready polling.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    err_timeout_d = err_timeout_q;
    err_badop_d   = err_badop_q;
    busy_d        = busy_q;
    sdi_d         = sdi_q;
    sii_d         = sii_q;
    frame_start   = 1'b0;
    cur_frame     = frame_lookup(op_q, idx_q, addr_q);

    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          op_d          = cmd_op;
          addr_d        = cmd_addr;
          idx_d         = '0;
          cnt_d         = '0;
          result_d      = '0;
          err_timeout_d = 1'b0;
          err_badop_d   = 1'b0;
          busy_d        = 1'b1;
          if (cmd_op == OpNop) begin
            state_d = StDone;
          end else if (cmd_op > OpChipErase) begin
            err_badop_d = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = StIssue;
          end
        end else begin
          // busy stays up for the first IDLE cycle after DONE, then drops.
          busy_d = 1'b0;
        end
      end
      StIssue: begin
        frame_start = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        if (frame_done) begin
          if (cur_frame.cap_lo) result_d[7:0] = frame_sdo[9:2];
          if (cur_frame.cap_hi) result_d[15:8] = frame_sdo[9:2];
          if (cur_frame.last) begin
            cnt_d   = '0;
            state_d = (op_q == OpChipErase) ? StPoll : StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StIssue;
          end
        end
      end
      StPoll: begin
        if ((cnt_q >= SettleLast) && sdo_sync_q) begin
          state_d = StDone;
        end else if (cnt_q >= TimeoutLast) begin
          err_timeout_d = 1'b1;
          state_d       = StDone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // SDI/SII are loaded on entry to ISSUE and held until the next one.
    nxt_frame = frame_lookup(op_d, idx_d, addr_d);
    if ((state_d == StIssue) && (state_q != StIssue)) begin
      sdi_d = nxt_frame.sdi;
      sii_d = nxt_frame.sii;
    end
  end

endmodule

// File: tb/tb_hvsp_op_sequencer.sv
// Bench for hvsp_op_sequencer: shifter model with a frame scoreboard plus
// per-scenario tasks.
module tb_hvsp_op_sequencer;

  localparam int unsigned Timeout = 1500;
  localparam int unsigned Settle  = 4;

  logic        osc = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0;
  logic        cmd_ready, busy, err_timeout, err_badop, frame_start;
  logic [15:0] result;
  logic [7:0]  frame_sdi, frame_sii;
  logic        frame_done = 1'b0;
  logic [10:0] frame_sdo = '0;
  logic        sdo_pin = 1'b0;

  int tests_run = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] sdi;
    logic [7:0] sii;
  } fr_t;

  fr_t         exp_q[$];
  logic [15:0] exp_res_q[$];
  logic [7:0]  resp [0:7];
  int          pending = 0;
  int          fnum = 0;
  int          starts = 0;
  int          done_cnt = 0;

  hvsp_op_sequencer #(
    .POLL_TIMEOUT(Timeout),
    .POLL_SETTLE (Settle)
  ) dut (
    .osc        (osc),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .result     (result),
    .err_timeout(err_timeout),
    .err_badop  (err_badop),
    .frame_sdi  (frame_sdi),
    .frame_sii  (frame_sii),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_sdo  (frame_sdo),
    .sdo_pin    (sdo_pin)
  );

  always #5 osc = ~osc;

  // Shifter model: checks each issued frame against the scoreboard, answers
  // with frame_done three cycles later carrying the programmed SDO byte.
  always @(negedge osc) begin
    if (!rst_n) begin
      pending    = 0;
      frame_done = 1'b0;
    end else begin
      frame_done = 1'b0;
      if (pending > 0) begin
        pending = pending - 1;
        if (pending == 0) begin
          frame_done = 1'b1;
          frame_sdo  = {1'b0, resp[fnum[2:0]], 2'b00};
          done_cnt   = done_cnt + 1;
        end
      end
      if (frame_start) begin
        fnum    = fnum + 1;
        starts  = starts + 1;
        pending = 3;
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_%0d: got %h/%h, want no frame", fnum, frame_sdi, frame_sii);
        end else begin
          fr_t e;
          e = exp_q.pop_front();
          if ({frame_sdi, frame_sii} !== {e.sdi, e.sii}) begin
            fails++;
            $display("FAIL frame_%0d: got %h/%h, want %h/%h", fnum, frame_sdi, frame_sii,
                     e.sdi, e.sii);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge osc);
    #1;
  endtask

  task automatic push_fr(input logic [7:0] sdi, input logic [7:0] sii);
    exp_q.push_back('{sdi: sdi, sii: sii});
  endtask

  task automatic push_frames(input logic [2:0] op, input logic [15:0] a);
    case (op)
      3'd1: begin
        push_fr(8'h02, 8'h4C); push_fr(a[7:0], 8'h0C); push_fr(a[15:8], 8'h1C);
        push_fr(8'h00, 8'h68); push_fr(8'h00, 8'h6C); push_fr(8'h00, 8'h78);
        push_fr(8'h00, 8'h7C);
      end
      3'd2: begin
        push_fr(8'h03, 8'h4C); push_fr(a[7:0], 8'h0C); push_fr(a[15:8], 8'h1C);
        push_fr(8'h00, 8'h68); push_fr(8'h00, 8'h6C);
      end
      3'd3: begin
        push_fr(8'h08, 8'h4C); push_fr(a[7:0], 8'h0C); push_fr(8'h00, 8'h68);
        push_fr(8'h00, 8'h6C);
      end
      3'd4: begin
        push_fr(8'h80, 8'h4C); push_fr(8'h00, 8'h64); push_fr(8'h00, 8'h6C);
      end
      default: ;
    endcase
  endtask

  task automatic new_cmd();
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    fnum     = 0;
    starts   = 0;
    done_cnt = 0;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy && cycles < 5000) begin
      tick();
      cycles++;
    end
    if (busy) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles, want 0", name, cycles);
    end
  endtask

  task automatic check_done(input string name, input int want_frames, input logic want_tmo,
                            input logic want_bad);
    logic [15:0] want_res;
    want_res = exp_res_q.size() > 0 ? exp_res_q.pop_front() : 16'h0000;
    tests_run++;
    if (result !== want_res) begin
      fails++;
      $display("FAIL %s_result: got %h, want %h", name, result, want_res);
    end
    tests_run++;
    if (starts != want_frames) begin
      fails++;
      $display("FAIL %s_frames: got %0d, want %0d", name, starts, want_frames);
    end
    tests_run++;
    if ({err_timeout, err_badop} !== {want_tmo, want_bad}) begin
      fails++;
      $display("FAIL %s_errs: got %b%b, want %b%b", name, err_timeout, err_badop, want_tmo,
               want_bad);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_leftover: got %0d unissued frames, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic wait_done_count(input int n);
    int c;
    c = 0;
    while (done_cnt < n && c < 200) begin
      tick();
      c++;
    end
    tests_run++;
    if (done_cnt < n) begin
      fails++;
      $display("FAIL done_count: got %0d, want %0d", done_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({cmd_ready, busy, err_timeout, err_badop, frame_start} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, want 10000",
               {cmd_ready, busy, err_timeout, err_badop, frame_start});
    end
    tests_run++;
    if ({result, frame_sdi, frame_sii} !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h, want 0", {result, frame_sdi, frame_sii});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_flash();
    int cyc;
    new_cmd();
    resp[5] = 8'hAA;
    resp[7] = 8'h55;
    push_frames(3'd1, 16'h0123);
    exp_res_q.push_back(16'h55AA);
    send(3'd1, 16'h0123);
    tests_run++;
    if ({busy, frame_start, cmd_ready} !== 3'b110) begin
      fails++;
      $display("FAIL flash_latency: got busy/start/ready=%b, want 110",
               {busy, frame_start, cmd_ready});
    end
    wait_idle("flash", cyc);
    check_done("flash", 7, 1'b0, 1'b0);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL flash_ready: got %b, want 1", cmd_ready);
    end
  endtask

  task automatic test_read_sig();
    int cyc;
    new_cmd();
    resp[4] = 8'h07;
    push_frames(3'd3, 16'h0002);
    exp_res_q.push_back(16'h0007);
    send(3'd3, 16'h0002);
    wait_idle("sig", cyc);
    check_done("sig", 4, 1'b0, 1'b0);
  endtask

  task automatic test_erase_poll();
    int cyc;
    new_cmd();
    sdo_pin = 1'b0;
    push_frames(3'd4, 16'h0000);
    exp_res_q.push_back(16'h0000);
    send(3'd4, 16'h0000);
    wait_done_count(3);
    repeat (1000) tick();
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL erase_still_polling: got busy=%b, want 1", busy);
    end
    sdo_pin = 1'b1;
    wait_idle("erase", cyc);
    tests_run++;
    if (cyc < 1 || cyc > 8) begin
      fails++;
      $display("FAIL erase_poll_latency: got %0d cycles, want 1..8", cyc);
    end
    check_done("erase", 3, 1'b0, 1'b0);
    sdo_pin = 1'b0;
    tick();
  endtask

  task automatic test_erase_timeout();
    int cyc;
    new_cmd();
    sdo_pin = 1'b0;
    push_frames(3'd4, 16'h0000);
    exp_res_q.push_back(16'h0000);
    send(3'd4, 16'h0000);
    wait_done_count(3);
    wait_idle("erase_tmo", cyc);
    tests_run++;
    if (cyc < int'(Settle + Timeout) - 2 || cyc > int'(Settle + Timeout) + 2) begin
      fails++;
      $display("FAIL erase_tmo_latency: got %0d cycles, want %0d +/-2", cyc,
               Settle + Timeout);
    end
    check_done("erase_tmo", 3, 1'b1, 1'b0);
  endtask

  task automatic test_bad_op();
    int hi;
    new_cmd();
    send(3'd6, 16'h1234);
    hi = 0;
    while (busy && hi < 10) begin
      tests_run++;
      if (frame_start !== 1'b0) begin
        fails++;
        $display("FAIL badop_start: got %b, want 0", frame_start);
      end
      hi++;
      tick();
    end
    tests_run++;
    if (hi != 2) begin
      fails++;
      $display("FAIL badop_busy_len: got %0d cycles, want 2", hi);
    end
    check_done("badop", 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    new_cmd();
    resp[5] = 8'h12;
    resp[7] = 8'h34;
    push_frames(3'd1, 16'hBEEF);
    exp_res_q.push_back(16'h3412);
    send(3'd1, 16'hBEEF);
    repeat (6) tick();
    send(3'd3, 16'h0001);
    wait_idle("b2b", cyc);
    check_done("b2b", 7, 1'b0, 1'b0);
    repeat (3) tick();
    tests_run++;
    if ({busy, starts} !== {1'b0, 32'd7}) begin
      fails++;
      $display("FAIL b2b_no_queue: got busy=%b frames=%0d, want 0/7", busy, starts);
    end
  endtask

  task automatic test_reset_mid_op();
    int c;
    int cyc;
    new_cmd();
    push_frames(3'd1, 16'h0456);
    send(3'd1, 16'h0456);
    c = 0;
    while (starts < 3 && c < 100) begin
      tick();
      c++;
    end
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, cmd_ready, frame_start, err_timeout, err_badop} !== 5'b01000) begin
      fails++;
      $display("FAIL midreset_ctrl: got %b, want 01000",
               {busy, cmd_ready, frame_start, err_timeout, err_badop});
    end
    tests_run++;
    if ({result, frame_sdi, frame_sii} !== 32'h0) begin
      fails++;
      $display("FAIL midreset_data: got %h, want 0", {result, frame_sdi, frame_sii});
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    new_cmd();
    resp[5] = 8'h3C;
    push_frames(3'd2, 16'h0040);
    exp_res_q.push_back(16'h003C);
    send(3'd2, 16'h0040);
    wait_idle("eeprom", cyc);
    check_done("eeprom", 5, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    test_reset();
    test_read_flash();
    test_read_sig();
    test_erase_poll();
    test_erase_timeout();
    test_bad_op();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
